// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - four-way arbiter in front of the shared RTC bus transaction engine
// Define RTC_ARB_RR_EN for round-robin among requesters 1-3; requester 0 always wins.
module rtc_bus_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [3:0]      req_lock,
  input  logic [3:0]      req_we,
  input  logic [4*AW-1:0] req_addr,
  input  logic [4*DW-1:0] req_wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            txn_start,
  output logic            txn_we,
  output logic [AW-1:0]   txn_addr,
  output logic [DW-1:0]   txn_wdata,
  input  logic            txn_busy,
  input  logic            txn_done,
  input  logic [DW-1:0]   txn_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC);

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [3:0]    gnt_q;
  logic [3:0]    ack_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          start_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [7:0]    tmo_q;
  logic [7:0]    tmo_d;

  logic          win_vld;
  logic [1:0]    win_idx;
  logic [1:0]    lat_idx;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          burst;

`ifdef RTC_ARB_RR_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_first;
  logic [2:0] cand;

  // Walk the ring backwards so the candidate closest to rr_first is assigned last and wins.
  always_comb begin
    win_vld  = |req;
    win_idx  = 2'd0;
    rr_first = (rr_ptr_q == 2'd3) ? 2'd1 : rr_ptr_q + 2'd1;
    cand     = 3'd0;
    if (!req[0]) begin
      for (int k = 2; k >= 0; k--) begin
        cand = {1'b0, rr_first} + 3'(k);
        if (cand > 3'd3) cand = cand - 3'd3;
        if (req[cand[1:0]]) win_idx = cand[1:0];
      end
    end
  end
`else
  always_comb begin
    win_vld = |req;
    win_idx = 2'd0;
    if (!req[0]) begin
      for (int k = 3; k >= 1; k--) begin
        if (req[k]) win_idx = 2'(k);
      end
    end
  end
`endif

  // In WAIT the only possible latch is a burst re-latch of the current owner.
  always_comb begin
    lat_idx   = (state_q == WAIT) ? idx_q : win_idx;
    lat_we    = req_we[lat_idx];
    lat_addr  = req_addr[lat_idx*AW +: AW];
    lat_wdata = req_wdata[lat_idx*DW +: DW];
    burst     = req_lock[idx_q] && req[idx_q];
    tmo_d     = tmo_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      gnt_q    <= 4'd0;
      ack_q    <= 4'd0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tmo_q    <= 8'd0;
`ifdef RTC_ARB_RR_EN
      rr_ptr_q <= 2'd0;
`endif
    end else begin
      start_q <= 1'b0;
      ack_q   <= 4'd0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld && !txn_busy) begin
            idx_q   <= win_idx;
            gnt_q   <= 4'b0001 << win_idx;
            we_q    <= lat_we;
            addr_q  <= lat_addr;
            wdata_q <= lat_wdata;
            start_q <= 1'b1;
            state_q <= ISSUE;
`ifdef RTC_ARB_RR_EN
            if (win_idx != 2'd0) rr_ptr_q <= win_idx;
`endif
          end
        end
        ISSUE: begin
          tmo_q   <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (txn_done) begin
            ack_q <= gnt_q;
            if (!we_q) rdata_q <= txn_rdata;
            if (burst) begin
              we_q    <= lat_we;
              addr_q  <= lat_addr;
              wdata_q <= lat_wdata;
              start_q <= 1'b1;
              state_q <= ISSUE;
            end else begin
              gnt_q   <= 4'd0;
              state_q <= IDLE;
            end
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == TMO_LAST) begin
              err_q   <= 1'b1;
              gnt_q   <= 4'd0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign txn_start = start_q;
  assign txn_we    = we_q;
  assign txn_addr  = addr_q;
  assign txn_wdata = wdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - self-checking bench for rtc_bus_arbiter
// Honours RTC_ARB_RR_EN in its arbitration model.
module tb_rtc_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      req = '0;
  logic [3:0]      req_lock = '0;
  logic [3:0]      req_we = '0;
  logic [4*AW-1:0] req_addr = '0;
  logic [4*DW-1:0] req_wdata = '0;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            txn_start;
  logic            txn_we;
  logic [AW-1:0]   txn_addr;
  logic [DW-1:0]   txn_wdata;
  logic            txn_busy = 1'b0;
  logic            txn_done = 1'b0;
  logic [DW-1:0]   txn_rdata = '0;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int rr_last = 0;
  logic [7:0] rdata_m = 8'h00;

  rtc_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .err(err), .txn_start(txn_start), .txn_we(txn_we), .txn_addr(txn_addr),
    .txn_wdata(txn_wdata), .txn_busy(txn_busy), .txn_done(txn_done), .txn_rdata(txn_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: 0 always first; others lowest-first, or rotating after the last non-zero winner.
  function automatic int pick(input logic [3:0] r, input int last);
    int c;
    if (r[0]) return 0;
`ifdef RTC_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      c = ((last + k - 1) % 3) + 1;
      if (r[c]) return c;
    end
`else
    for (int k = 1; k <= 3; k++) begin
      c = k;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  // Waits for the grant, checks the latched fields, completes after dly cycles, then drops req[idx].
  task automatic serve(input string tag, input int idx, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input int dly, input logic [7:0] rd);
    int n;
    n = 0;
    while (txn_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(txn_start), 32'd1);
    check({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << idx));
    check({tag, "_we"}, 32'(txn_we), 32'(we));
    check({tag, "_addr"}, 32'(txn_addr), 32'(addr));
    if (we) check({tag, "_wdata"}, 32'(txn_wdata), 32'(wdata));
    if (idx != 0) rr_last = idx;
    repeat (dly) tick();
    txn_done = 1'b1;
    txn_rdata = rd;
    tick();
    txn_done = 1'b0;
    if (!we) rdata_m = rd;
    check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << idx));
    check({tag, "_rdata"}, 32'(rdata), 32'(rdata_m));
    req[idx] = 1'b0;
  endtask

  int exp_order[3];
  int n;
  int w;
  logic ack_seen;

  initial begin
`ifdef RTC_ARB_RR_EN
    exp_order = '{3, 1, 2};
`else
    exp_order = '{1, 2, 3};
`endif
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_start", 32'(txn_start), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", 32'(rdata), 0);
    reset = 1'b0;

    // Single read from requester 3
    req_we[3] = 1'b0;
    req_addr[31:24] = 8'h21;
    req = 4'b1000;
    tick();
    check("rd_gnt", 32'(gnt), 32'h8);
    check("rd_start", 32'(txn_start), 1);
    check("rd_addr", 32'(txn_addr), 32'h21);
    check("rd_we", 32'(txn_we), 0);
    tick();
    check("rd_start_low", 32'(txn_start), 0);
    repeat (9) tick();
    txn_done = 1'b1;
    txn_rdata = 8'h59;
    tick();
    txn_done = 1'b0;
    req = 4'b0000;
    rr_last = 3;
    rdata_m = 8'h59;
    check("rd_ack", 32'(ack), 32'h8);
    check("rd_rdata", 32'(rdata), 32'h59);
    check("rd_gnt_clr", 32'(gnt), 0);
    tick();
    check("rd_ack_low", 32'(ack), 0);

    // Busy gating, then a stray done in IDLE
    txn_busy = 1'b1;
    req_we[2] = 1'b0;
    req_addr[23:16] = 8'h52;
    req = 4'b0100;
    repeat (4) tick();
    check("busy_gnt", 32'(gnt), 0);
    check("busy_start", 32'(txn_start), 0);
    txn_busy = 1'b0;
    tick();
    check("busy_release_gnt", 32'(gnt), 32'h4);
    serve("busy", 2, 1'b0, 8'h52, 8'h00, 3, 8'hC3);
    tick();
    txn_done = 1'b1;
    txn_rdata = 8'hFF;
    tick();
    txn_done = 1'b0;
    check("stray_ack", 32'(ack), 0);
    check("stray_gnt", 32'(gnt), 0);
    check("stray_start", 32'(txn_start), 0);
    check("stray_rdata", 32'(rdata), 32'(rdata_m));

    // Contention among 1..3, each releasing on its ack; previous winner was 2
    for (int j = 1; j <= 3; j++) begin
      req_we[j] = 1'b0;
      req_addr[j*8 +: 8] = 8'(8'h10 * j);
    end
    req = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      w = pick(req, rr_last);
      check("cont_model", 32'(w), 32'(exp_order[k]));
      serve("cont", exp_order[k], 1'b0, 8'(8'h10 * exp_order[k]), 8'h00, 2, 8'(8'h80 + k));
    end

    // Locked burst of 9 writes from requester 0 with requester 3 waiting
    req_lock = 4'b0001;
    req_we[0] = 1'b1;
    req_addr[7:0] = 8'h00;
    req_wdata[7:0] = 8'hA0;
    req_we[3] = 1'b0;
    req_addr[31:24] = 8'h33;
    req = 4'b1001;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("burst_start", 32'(txn_start), 1);
      check("burst_gnt", 32'(gnt), 1);
      check("burst_addr", 32'(txn_addr), 32'(i));
      check("burst_wdata", 32'(txn_wdata), 32'(8'hA0 + i));
      if (i == 8) begin
        req_lock = 4'b0000;
        req[0] = 1'b0;
      end else begin
        req_addr[7:0] = 8'(i + 1);
        req_wdata[7:0] = 8'(8'hA0 + i + 1);
      end
      repeat (1 + $urandom_range(0, 3)) tick();
      check("burst_hold", 32'(gnt), 1);
      txn_done = 1'b1;
      txn_rdata = 8'hEE;
      tick();
      txn_done = 1'b0;
      check("burst_ack", 32'(ack), 1);
      check("burst_rdata", 32'(rdata), 32'(rdata_m));
    end
    check("burst_end_gnt", 32'(gnt), 0);
    tick();
    check("after_burst_gnt", 32'(gnt), 32'h8);
    serve("after_burst", 3, 1'b0, 8'h33, 8'h00, 2, 8'h4D);

    // Timeout on a requester 1 write
    req_we[1] = 1'b1;
    req_addr[15:8] = 8'h44;
    req_wdata[15:8] = 8'h55;
    req = 4'b0010;
    tick();
    check("tmo_start", 32'(txn_start), 1);
    rr_last = 1;
    n = 0;
    ack_seen = 1'b0;
    while (err !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (ack !== 4'b0000) ack_seen = 1'b1;
    end
    check("tmo_cycles", 32'(n), 32'd256);
    check("tmo_gnt", 32'(gnt), 0);
    check("tmo_noack", 32'(ack_seen), 0);
    req = 4'b0000;
    tick();
    check("tmo_err_low", 32'(err), 0);
    req_we[1] = 1'b0;
    req = 4'b0010;
    serve("post_tmo", 1, 1'b0, 8'h44, 8'h00, 4, 8'h7E);

    // Randomized request sets, each drained completely
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 4; j++) begin
        req_we[j] = 1'($urandom);
        req_addr[j*8 +: 8] = 8'($urandom);
        req_wdata[j*8 +: 8] = 8'($urandom);
      end
      req = 4'($urandom_range(1, 15));
      while (req != 4'b0000) begin
        w = pick(req, rr_last);
        serve("rand", w, req_we[w], req_addr[w*8 +: 8], req_wdata[w*8 +: 8],
              $urandom_range(1, 6), 8'($urandom));
      end
      tick();
      check("rand_idle_gnt", 32'(gnt), 0);
    end

    // Reset during a requester 2 transaction
    req_we[2] = 1'b1;
    req_addr[23:16] = 8'h66;
    req_wdata[23:16] = 8'h99;
    req = 4'b0100;
    repeat (3) tick();
    check("mid_gnt", 32'(gnt), 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0000;
    check("mrst_gnt", 32'(gnt), 0);
    check("mrst_ack", 32'(ack), 0);
    check("mrst_rdata", 32'(rdata), 0);
    check("mrst_start", 32'(txn_start), 0);
    check("mrst_fields", {txn_we, txn_addr, txn_wdata, err}, 0);
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    check("mrst_done_ack", 32'(ack), 0);
    check("mrst_done_gnt", 32'(gnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
